banco_registros_param: RTL and testbench



---
 rtl/banco_registros_param_if.sv | 30 +++
 rtl/banco_registros_param.sv | 124 ++++++++++++
 tb/tb_banco_registros_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/banco_registros_param_if.sv
// Request/response bus between the instruction decoder and the register bank.
interface banco_registros_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        op;
    logic [ADDR_W-1:0] select_reg;
    logic [ADDR_W-1:0] select_reg_b;
    logic              size;
    logic              select_high_low;
    logic              select_data_h_reg;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              err;

    modport master (
        output req_valid, op, select_reg, select_reg_b, size,
               select_high_low, select_data_h_reg, data_in,
        input  req_ready, data_out, data_valid, err
    );

    modport slave (
        input  req_valid, op, select_reg, select_reg_b, size,
               select_high_low, select_data_h_reg, data_in,
        output req_ready, data_out, data_valid, err
    );
endinterface

// File: rtl/banco_registros_param.sv
// Parametrised register bank: full/half-width write and read, two-cycle exchange,
// valid/ready request handshake with registered read data and error pulse.
module banco_registros_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
    parameter int unsigned HALF_REGS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    banco_registros_param_if.slave bus
);
    localparam int unsigned H = DATA_W / 2;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_XCHG  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XCHG = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] tmp;
    logic [ADDR_W-1:0] xchg_a;
    logic [ADDR_W-1:0] xchg_b;

    logic              accept_c;
    logic              bad_a_c;
    logic              bad_b_c;
    logic              bad_half_c;
    logic              err_c;
    logic [H-1:0]      half_src_c;
    logic [DATA_W-1:0] rd_full_c;
    logic [H-1:0]      rd_half_c;
    logic [DATA_W-1:0] wr_val_c;

    // Request decode: legality, read mux and merged write value for register A.
    always_comb begin
        accept_c   = bus.req_valid & bus.req_ready;
        bad_a_c    = 32'(bus.select_reg) >= NUM_REGS;
        bad_b_c    = 32'(bus.select_reg_b) >= NUM_REGS;
        bad_half_c = !bus.size && (32'(bus.select_reg) >= HALF_REGS);
        err_c      = 1'b0;
        case (bus.op)
            OP_WRITE, OP_READ: err_c = bad_a_c | bad_half_c;
            OP_XCHG:           err_c = bad_a_c | bad_b_c;
            default:           err_c = 1'b0;
        endcase

        rd_full_c  = bad_a_c ? '0 : regs[bus.select_reg];
        rd_half_c  = bus.select_high_low ? rd_full_c[DATA_W-1:H] : rd_full_c[H-1:0];
        half_src_c = bus.select_data_h_reg ? bus.data_in[DATA_W-1:H] : bus.data_in[H-1:0];

        wr_val_c = rd_full_c;
        if (bus.size) begin
            wr_val_c = bus.data_in;
        end else if (bus.select_high_low) begin
            wr_val_c[DATA_W-1:H] = half_src_c;
        end else begin
            wr_val_c[H-1:0] = half_src_c;
        end
    end

    // Control FSM, register array and registered responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            tmp            <= '0;
            xchg_a         <= '0;
            xchg_b         <= '0;
            state          <= ST_IDLE;
            bus.req_ready  <= 1'b1;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (err_c) begin
                            bus.err <= 1'b1;
                        end else begin
                            case (bus.op)
                                OP_WRITE: regs[bus.select_reg] <= wr_val_c;
                                OP_READ: begin
                                    bus.data_out   <= bus.size ? rd_full_c : DATA_W'(rd_half_c);
                                    bus.data_valid <= 1'b1;
                                end
                                OP_XCHG: begin
                                    tmp           <= rd_full_c;
                                    xchg_a        <= bus.select_reg;
                                    xchg_b        <= bus.select_reg_b;
                                    state         <= ST_XCHG;
                                    bus.req_ready <= 1'b0;
                                end
                                OP_NOP:  ;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_XCHG: begin
                    // B is written last so A == B leaves the register unchanged.
                    regs[xchg_a]  <= regs[xchg_b];
                    regs[xchg_b]  <= tmp;
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_banco_registros_param.sv
// Scoreboard bench for banco_registros_param: directed scenarios plus random traffic
// against an array-based reference model.
module tb_banco_registros_param;
    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int HR = 4;

    localparam logic [1:0] NOP = 2'b00, WR = 2'b01, RD = 2'b10, XC = 2'b11;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    banco_registros_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    banco_registros_param #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .HALF_REGS(HR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    logic [15:0] model[NR];
    logic [15:0] last_data = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: apply an accepted request and queue the expected response.
    task automatic model_accept(input logic [1:0] op, input int a, input int b, input bit sz,
                                input bit hl, input bit dh, input logic [15:0] din);
        exp_t       e;
        logic [7:0] src;
        logic [15:0] t;
        case (op)
            WR: begin
                if (!sz && a >= HR) begin
                    e.is_err = 1; e.data = 0; q.push_back(e);
                end else if (sz) begin
                    model[a] = din;
                end else begin
                    src = dh ? din[15:8] : din[7:0];
                    if (hl) model[a] = {src, model[a][7:0]};
                    else    model[a] = {model[a][15:8], src};
                end
            end
            RD: begin
                if (!sz && a >= HR) begin
                    e.is_err = 1; e.data = 0;
                end else begin
                    e.is_err = 0;
                    t = model[a];
                    e.data = sz ? t : (hl ? {8'h00, t[15:8]} : {8'h00, t[7:0]});
                end
                q.push_back(e);
            end
            XC: begin
                t = model[a]; model[a] = model[b]; model[b] = t;
            end
            default: ;
        endcase
    endtask

    // Drive one request, hold it until accepted; returns cycles spent stalled.
    task automatic issue(input logic [1:0] op, input int a, input int b, input bit sz,
                         input bit hl, input bit dh, input logic [15:0] din, output int stalls);
        @(negedge clk);
        bus.req_valid         = 1'b1;
        bus.op                = op;
        bus.select_reg        = AW'(a);
        bus.select_reg_b      = AW'(b);
        bus.size              = sz;
        bus.select_high_low   = hl;
        bus.select_data_h_reg = dh;
        bus.data_in           = din;
        stalls = 0;
        while (bus.req_ready !== 1'b1) begin
            stalls++;
            if (stalls > 20) begin
                total++; bad++;
                $display("FAIL accept_timeout actual=stalled required=accepted t=%0t", $time);
                bus.req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        model_accept(op, a, b, sz, hl, dh, din);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.op        = NOP;
    endtask

    // Monitor: pop and compare whenever the DUT presents a response; check hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_data = 16'h0;
        end else if (bus.data_valid || bus.err) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp actual=valid%b_err%b required=none t=%0t",
                         bus.data_valid, bus.err, $time);
            end else begin
                e = q.pop_front();
                check("resp_err", 32'(bus.err), 32'(e.is_err));
                check("resp_valid", 32'(bus.data_valid), 32'(!e.is_err));
                if (!e.is_err) begin
                    check("read_data", 32'(bus.data_out), 32'(e.data));
                    last_data = e.data;
                end else begin
                    check("data_hold_err", 32'(bus.data_out), 32'(last_data));
                end
            end
        end else begin
            check("data_hold", 32'(bus.data_out), 32'(last_data));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int a, b;
        logic [1:0] op;
        bus.req_valid = 0; bus.op = NOP; bus.select_reg = 0; bus.select_reg_b = 0;
        bus.size = 1; bus.select_high_low = 0; bus.select_data_h_reg = 0; bus.data_in = 0;
        for (int i = 0; i < NR; i++) model[i] = 16'h0;

        // 1. reset, then read every register
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_dout", 32'(bus.data_out), 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) issue(RD, i, 0, 1, 0, 0, 16'h0, st);

        // 2. full write then read next cycle
        issue(WR, 3, 0, 1, 0, 0, 16'hBEEF, st);
        issue(RD, 3, 0, 1, 0, 0, 16'h0, st);

        // 3. half-lane writes and reads
        issue(WR, 1, 0, 1, 0, 0, 16'h1234, st);
        issue(WR, 1, 0, 0, 1, 1, 16'hAB00, st);
        issue(RD, 1, 0, 1, 0, 0, 16'h0, st);
        issue(WR, 1, 0, 0, 0, 0, 16'h00CD, st);
        issue(RD, 1, 0, 1, 0, 0, 16'h0, st);
        issue(RD, 1, 0, 0, 1, 0, 16'h0, st);
        issue(RD, 1, 0, 0, 0, 0, 16'h0, st);
        issue(WR, 2, 0, 0, 0, 1, 16'h5A77, st);
        issue(RD, 2, 0, 1, 0, 0, 16'h0, st);

        // 4. half access to a full-only register is rejected
        issue(WR, 6, 0, 1, 0, 0, 16'h6666, st);
        issue(WR, 6, 0, 0, 1, 0, 16'hFFFF, st);
        issue(RD, 6, 0, 0, 0, 0, 16'h0, st);
        issue(RD, 6, 0, 1, 0, 0, 16'h0, st);

        // 5. exchange; a held request waits exactly one cycle
        issue(WR, 0, 0, 1, 0, 0, 16'h1111, st);
        issue(WR, 2, 0, 1, 0, 0, 16'h2222, st);
        issue(XC, 0, 2, 0, 1, 1, 16'hFFFF, st);
        check("xchg_no_stall", 32'(st), 32'd0);
        issue(RD, 0, 0, 1, 0, 0, 16'h0, st);
        check("xchg_stall_cycles", 32'(st), 32'd1);
        issue(RD, 2, 0, 1, 0, 0, 16'h0, st);
        issue(WR, 5, 0, 1, 0, 0, 16'hC0DE, st);
        issue(XC, 5, 5, 1, 0, 0, 16'h0, st);
        issue(RD, 5, 0, 1, 0, 0, 16'h0, st);
        check("xchg_same_stall", 32'(st), 32'd1);

        // 6. reset during the exchange cycle
        issue(WR, 4, 0, 1, 0, 0, 16'h1111, st);
        issue(WR, 7, 0, 1, 0, 0, 16'h2222, st);
        issue(XC, 4, 7, 1, 0, 0, 16'h0, st);
        @(negedge clk);
        check("xchg_ready_low", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        last_data = 16'h0;
        reset = 1'b0;
        q.delete();
        for (int i = 0; i < NR; i++) model[i] = 16'h0;
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < NR; i++) issue(RD, i, 0, 1, 0, 0, 16'h0, st);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, NR - 1));
            b  = int'($urandom_range(0, NR - 1));
            issue(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), st);
        end
        for (int i = 0; i < NR; i++) issue(RD, i, 0, 1, 0, 0, 16'h0, st);

        repeat (3) @(negedge clk);
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
